// File: rtl/ldpc_sched_pkg.sv
// Shared types and constants for the LDPC decoder frame scheduler.
package ldpc_sched_pkg;
    localparam int cBEATS = 288;
    localparam int cBEAT_W = $clog2(cBEATS);
    localparam int cCNT_W = 16;
    localparam int cRST_PULSE = 4;

    typedef enum logic [1:0] {IDLE, FEED, DROP} state_t;

    function automatic logic [cCNT_W-1:0] sat_inc(
        input logic [cCNT_W-1:0] v,
        input logic en
    );
        return (en && v != '1) ? v + cCNT_W'(1) : v;
    endfunction
endpackage

// File: rtl/ldpc_dec_sched_if.sv
// Scheduler-to-decoder port bundle; master is the scheduler,
// slave is the LDPC decoder.
interface ldpc_dec_sched_if #(
    parameter int pLLR_W = 5,
    parameter int pLLR_NUM = 8,
    parameter int pTAG_W = 4
);
    logic                       dec_ival;
    logic                       dec_isop;
    logic                       dec_ieop;
    logic [pLLR_W*pLLR_NUM-1:0] dec_iLLR;
    logic [pTAG_W-1:0]          dec_itag;
    logic [7:0]                 dec_iNiter;
    logic                       dec_rst_n;
    logic                       dec_ordy;
    logic                       dec_oeop;
    logic [pTAG_W-1:0]          dec_otag;
    logic                       dec_odecfail;

    modport master (
        output dec_ival, dec_isop, dec_ieop, dec_iLLR,
        output dec_itag, dec_iNiter, dec_rst_n,
        input  dec_ordy, dec_oeop, dec_otag, dec_odecfail
    );

    modport slave (
        input  dec_ival, dec_isop, dec_ieop, dec_iLLR,
        input  dec_itag, dec_iNiter, dec_rst_n,
        output dec_ordy, dec_oeop, dec_otag, dec_odecfail
    );
endinterface

// File: rtl/ldpc_sched_wdog.sv
// Decoder watchdog: counts while frames are in flight, fires after
// pTIMEOUT idle cycles and stretches a soft-reset pulse.
module ldpc_sched_wdog
    import ldpc_sched_pkg::*;
#(
    parameter int pTIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic kick,
    output logic fire,
    output logic rst_n
);
    localparam int cW = $clog2(pTIMEOUT + 1);
    localparam int cPW = $clog2(cRST_PULSE + 1);

    logic [cW-1:0]  cnt;
    logic [cPW-1:0] pulse;

    assign fire = active && !kick && (cnt == cW'(pTIMEOUT - 1));
    assign rst_n = (pulse == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            pulse <= '0;
        end else begin
            if (!active || kick || fire)
                cnt <= '0;
            else
                cnt <= cnt + cW'(1);
            if (fire)
                pulse <= cPW'(cRST_PULSE);
            else if (pulse != '0)
                pulse <= pulse - cPW'(1);
        end
    end
endmodule

// File: rtl/ldpc_dec_sched.sv
// Whole-codeword admission scheduler in front of ldpc_dec.
// LDPC_SCHED_ADAPTIVE_NITER_EN: pick reduced iterations when FIFO is full.
module ldpc_dec_sched
    import ldpc_sched_pkg::*;
#(
    parameter int pBEATS = cBEATS,
    parameter int pLLR_W = 5,
    parameter int pLLR_NUM = 8,
    parameter int pTAG_W = 4,
    parameter int pMAX_INFL = 2,
    parameter int pTIMEOUT = 65535,
    parameter int pLVL_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ival,
    input  logic                       isop,
    input  logic                       ieof,
    input  logic [pLLR_W*pLLR_NUM-1:0] iLLR,
    ldpc_dec_sched_if.master           dec,
    input  logic [7:0]                 cfg_niter_max,
    input  logic [7:0]                 cfg_niter_min,
    input  logic [pLVL_W-1:0]          cfg_lvl_hi,
    input  logic [pLVL_W-1:0]          fifo_level,
    output logic [cCNT_W-1:0]          cnt_ok,
    output logic [cCNT_W-1:0]          cnt_fail,
    output logic [cCNT_W-1:0]          cnt_drop,
    output logic                       evt_err
);
    localparam int cINF_W = $clog2(pMAX_INFL + 1);

    state_t              state, state_n;
    logic [cBEAT_W-1:0]  beat_cnt, beat_cnt_n;
    logic [cINF_W-1:0]   infl;
    logic [pTAG_W-1:0]   tag_q, exp_tag;
    logic fwd, sop, eop, admit, drop_inc, short_err;
    logic frame_end, decide, last, fire, wd_rst_n;
    logic done, tag_err;

    assign done = dec.dec_oeop && (infl != '0);
    assign tag_err = dec.dec_oeop && (dec.dec_otag != exp_tag);
    assign dec.dec_rst_n = wd_rst_n;

`ifdef LDPC_SCHED_ADAPTIVE_NITER_EN
    logic [7:0] niter_sel;
    assign niter_sel = (fifo_level >= cfg_lvl_hi) ? cfg_niter_min
                                                  : cfg_niter_max;
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_niter_min, cfg_lvl_hi, fifo_level};
`endif

    ldpc_sched_wdog #(.pTIMEOUT(pTIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .active (infl != '0),
        .kick   (dec.dec_oeop),
        .fire   (fire),
        .rst_n  (wd_rst_n)
    );

    always_comb begin
        state_n = state;
        beat_cnt_n = beat_cnt;
        fwd = 1'b0;
        sop = 1'b0;
        eop = 1'b0;
        admit = 1'b0;
        drop_inc = 1'b0;
        short_err = 1'b0;
        frame_end = 1'b0;
        decide = 1'b0;
        last = (beat_cnt == cBEAT_W'(pBEATS - 1));
        unique case (state)
            IDLE: decide = ival && isop;
            FEED: if (ival) begin
                fwd = 1'b1;
                beat_cnt_n = beat_cnt + cBEAT_W'(1);
                if (last || ieof) begin
                    eop = 1'b1;
                    frame_end = 1'b1;
                    short_err = !last;
                    state_n = IDLE;
                end
            end
            DROP: if (ival) begin
                beat_cnt_n = beat_cnt + cBEAT_W'(1);
                if (last || ieof) begin
                    state_n = IDLE;
                    decide = isop;
                end
            end
            default: state_n = IDLE;
        endcase
        if (decide) begin
            beat_cnt_n = cBEAT_W'(1);
            if (dec.dec_ordy && infl < cINF_W'(pMAX_INFL) && !fire) begin
                state_n = FEED;
                fwd = 1'b1;
                sop = 1'b1;
                admit = 1'b1;
            end else begin
                state_n = DROP;
                drop_inc = 1'b1;
            end
        end
        // the decoder is being flushed: abandon the frame being fed
        if (fire && state == FEED) begin
            state_n = DROP;
            fwd = 1'b0;
            eop = 1'b0;
            frame_end = 1'b0;
            short_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            beat_cnt <= '0;
            infl <= '0;
            tag_q <= '0;
            exp_tag <= '0;
            dec.dec_ival <= 1'b0;
            dec.dec_isop <= 1'b0;
            dec.dec_ieop <= 1'b0;
            dec.dec_iLLR <= '0;
            dec.dec_itag <= '0;
            dec.dec_iNiter <= cfg_niter_max;
            cnt_ok <= '0;
            cnt_fail <= '0;
            cnt_drop <= '0;
            evt_err <= 1'b0;
        end else begin
            state <= state_n;
            beat_cnt <= beat_cnt_n;
            dec.dec_ival <= fwd;
            dec.dec_isop <= sop;
            dec.dec_ieop <= eop;
            if (fwd)
                dec.dec_iLLR <= iLLR;
            dec.dec_itag <= tag_q;
            if (frame_end)
                tag_q <= tag_q + pTAG_W'(1);
`ifdef LDPC_SCHED_ADAPTIVE_NITER_EN
            if (admit)
                dec.dec_iNiter <= niter_sel;
`else
            dec.dec_iNiter <= cfg_niter_max;
`endif
            if (fire)
                infl <= '0;
            else if (frame_end && !done)
                infl <= infl + cINF_W'(1);
            else if (!frame_end && done)
                infl <= infl - cINF_W'(1);
            // a matching tag and a resync both land on otag+1
            if (fire)
                exp_tag <= dec.dec_itag;
            else if (dec.dec_oeop)
                exp_tag <= dec.dec_otag + pTAG_W'(1);
            cnt_ok <= sat_inc(cnt_ok, dec.dec_oeop && !dec.dec_odecfail);
            cnt_fail <= sat_inc(cnt_fail, dec.dec_oeop && dec.dec_odecfail);
            cnt_drop <= sat_inc(cnt_drop, drop_inc);
            evt_err <= short_err || tag_err || fire;
        end
    end
endmodule

// File: tb/tb_ldpc_dec_sched.sv
// Directed self-checking bench for ldpc_dec_sched (watchdog at 1000).
module tb_ldpc_dec_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ival = 1'b0, isop = 1'b0, ieof = 1'b0;
    logic [39:0] iLLR = '0;
    logic [7:0]  cfg_niter_max = 8'd10, cfg_niter_min = 8'd4;
    logic [9:0]  cfg_lvl_hi = 10'd512, fifo_level = 10'd100;
    logic [15:0] cnt_ok, cnt_fail, cnt_drop;
    logic        evt_err;

    always #5 clk = ~clk;

    ldpc_dec_sched_if dif ();

    ldpc_dec_sched #(.pTIMEOUT(1000)) dut (
        .clk           (clk),
        .rst           (rst),
        .ival          (ival),
        .isop          (isop),
        .ieof          (ieof),
        .iLLR          (iLLR),
        .dec           (dif),
        .cfg_niter_max (cfg_niter_max),
        .cfg_niter_min (cfg_niter_min),
        .cfg_lvl_hi    (cfg_lvl_hi),
        .fifo_level    (fifo_level),
        .cnt_ok        (cnt_ok),
        .cnt_fail      (cnt_fail),
        .cnt_drop      (cnt_drop),
        .evt_err       (evt_err)
    );

    int n_chk = 0, n_fail = 0;
    int f_val, f_sop, f_eop, f_tag, f_niter, f_err, f_bad, c_err;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] llr_of(input int i);
        return {5{i[7:0]}};
    endfunction

    function automatic int exp_niter(input int lvl);
`ifdef LDPC_SCHED_ADAPTIVE_NITER_EN
        return (lvl >= 512) ? 4 : 10;
`else
        return 10 + 0 * lvl;
`endif
    endfunction

    task automatic send(input int n);
        f_val = 0; f_sop = -1; f_eop = -1; f_tag = -1;
        f_niter = -1; f_err = 0; f_bad = 0;
        for (int i = 0; i < n; i++) begin
            ival = 1'b1;
            isop = (i == 0);
            ieof = (i == n - 1);
            iLLR = llr_of(i);
            step;
            if (dif.dec_ival) begin
                f_val++;
                if (dif.dec_iLLR !== llr_of(i)) f_bad++;
            end
            if (dif.dec_isop) begin
                f_sop = i;
                f_tag = int'(dif.dec_itag);
                f_niter = int'(dif.dec_iNiter);
            end
            if (dif.dec_ieop) f_eop = i;
            if (evt_err) f_err++;
        end
        ival = 1'b0; isop = 1'b0; ieof = 1'b0;
        step;
        if (evt_err) f_err++;
    endtask

    task automatic done(input int t, input bit fail);
        dif.dec_oeop = 1'b1;
        dif.dec_otag = 4'(t);
        dif.dec_odecfail = fail;
        step;
        c_err = int'(evt_err);
        dif.dec_oeop = 1'b0;
        dif.dec_odecfail = 1'b0;
    endtask

    initial begin
        int first_low, lows, first_err, errs;
        dif.dec_ordy = 1'b1;
        dif.dec_oeop = 1'b0;
        dif.dec_otag = '0;
        dif.dec_odecfail = 1'b0;
        repeat (3) step;
        check("rst_ival", dif.dec_ival, 0);
        check("rst_sop", dif.dec_isop, 0);
        check("rst_eop", dif.dec_ieop, 0);
        check("rst_llr", dif.dec_iLLR, 0);
        check("rst_tag", dif.dec_itag, 0);
        check("rst_niter", dif.dec_iNiter, 10);
        check("rst_rstn", dif.dec_rst_n, 1);
        check("rst_cnt", {cnt_ok, cnt_fail, cnt_drop}, 0);
        check("rst_err", evt_err, 0);
        rst = 1'b1;
        step;

        send(288);
        check("f0_val", f_val, 288);
        check("f0_sop", f_sop, 0);
        check("f0_eop", f_eop, 287);
        check("f0_tag", f_tag, 0);
        check("f0_niter", f_niter, exp_niter(100));
        check("f0_llr", f_bad, 0);
        check("f0_err", f_err, 0);
        done(0, 0);
        check("f0_cerr", c_err, 0);
        check("f0_ok", cnt_ok, 1);
        check("f0_infl", dut.infl, 0);

        send(288);
        check("f1_tag", f_tag, 1);
        check("f1_eop", f_eop, 287);
        send(288);
        check("f2_tag", f_tag, 2);
        check("f2_infl", dut.infl, 2);
        send(288);
        check("f3_val", f_val, 0);
        check("f3_drop", cnt_drop, 1);
        done(1, 0);
        check("f1_cerr", c_err, 0);
        done(2, 0);
        check("f2_cerr", c_err, 0);
        check("f2_ok", cnt_ok, 3);
        dif.dec_ordy = 1'b0;
        send(10);
        check("nordy_val", f_val, 0);
        check("nordy_drop", cnt_drop, 2);
        dif.dec_ordy = 1'b1;

        fifo_level = 10'd600;
        send(101);
        check("short_eop", f_eop, 100);
        check("short_val", f_val, 101);
        check("short_err", f_err, 1);
        check("short_tag", f_tag, 3);
        check("short_niter", f_niter, exp_niter(600));
        fifo_level = 10'd100;
        send(288);
        check("f5_val", f_val, 288);
        check("f5_tag", f_tag, 4);
        check("f5_err", f_err, 0);
        check("f5_niter", f_niter, exp_niter(100));
        done(3, 0);
        check("f4_cerr", c_err, 0);
        done(4, 1);
        check("f5_cerr", c_err, 0);
        check("f5_ok", cnt_ok, 4);
        check("f5_fail", cnt_fail, 1);

        send(288);
        check("f6_tag", f_tag, 5);
        done(7, 0);
        check("mis_err", c_err, 1);
        done(8, 0);
        check("resync_err", c_err, 0);
        check("resync_ok", cnt_ok, 6);
        check("resync_infl", dut.infl, 0);

        send(288);
        check("wd_tag", f_tag, 6);
        first_low = -1; lows = 0; first_err = -1; errs = 0;
        for (int j = 2; j <= 1100; j++) begin
            step;
            if (!dif.dec_rst_n) begin
                lows++;
                if (first_low < 0) first_low = j;
            end
            if (evt_err) begin
                errs++;
                if (first_err < 0) first_err = j;
            end
        end
        check("wd_first", first_low, 1000);
        check("wd_lows", lows, 4);
        check("wd_errs", errs, 1);
        check("wd_errat", first_err, 1000);
        check("wd_infl", dut.infl, 0);
        send(288);
        check("wd_next_val", f_val, 288);
        check("wd_next_tag", f_tag, 7);
        done(7, 0);
        check("wd_cerr", c_err, 0);
        check("wd_ok", cnt_ok, 7);

        for (int i = 0; i < 50; i++) begin
            ival = 1'b1; isop = (i == 0); ieof = 1'b0; iLLR = llr_of(i);
            step;
        end
        rst = 1'b0;
        step;
        check("mrst_ival", dif.dec_ival, 0);
        check("mrst_eop", dif.dec_ieop, 0);
        check("mrst_ok", cnt_ok, 0);
        ival = 1'b0; isop = 1'b0;
        rst = 1'b1;
        step;
        send(288);
        check("mrst_tag", f_tag, 0);
        check("mrst_val", f_val, 288);
        check("mrst_eopat", f_eop, 287);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
